// File: rtl/icache_stream_prefetch.sv
// Single-stream sequential prefetch buffer between the icache line-fill port and imem.
// Optional statistics counters are compiled in when PREFETCH_STATS_EN is defined.
module icache_stream_prefetch #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic [31:0]           req_rdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]           dbg_hit_count,
    output logic [31:0]           dbg_miss_count,
    output logic [31:0]           dbg_pf_issue_count
`endif
);

    localparam int              PW   = $clog2(DEPTH);
    localparam logic [PW:0]     FULL = (PW+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);

    typedef enum logic [2:0] {IDLE, HIT_RSP, WAIT_PF, DRAIN, DEMAND, DEMAND_RSP} state_e;

    state_e                  state_q;
    logic                    req_ready_q;
    logic [31:0]             req_rdata_q;
    logic                    mem_valid_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [ADDR_WIDTH-1:0]   head_addr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [PW:0]             vcnt_q, vcnt_d;
    logic                    active_q;
    logic [31:0]             buf_q [DEPTH];

    // Valid entries occupy rd_ptr..rd_ptr+vcnt-1; an in-flight prefetch is the entry just after.
    logic                  pf_busy, pf_done, idle_req, head_match;
    logic                  hit_fifo, wait_hit, miss, append, pf_issue;
    logic [PW-1:0]         wr_idx;
    logic [ADDR_WIDTH-1:0] pf_addr;

    assign pf_busy    = mem_valid_q && (state_q != DEMAND);
    assign pf_done    = pf_busy && mem_ready;
    assign idle_req   = (state_q == IDLE) && req_valid;
    assign head_match = (req_addr & WORD_MASK) == head_addr_q;
    assign hit_fifo   = idle_req && head_match && (vcnt_q != '0);
    assign wait_hit   = idle_req && head_match && (vcnt_q == '0) && pf_busy;
    assign miss       = idle_req && !hit_fifo && !wait_hit;
    assign append     = pf_done && ((state_q == HIT_RSP) ||
                                    ((state_q == IDLE) && (!req_valid || hit_fifo)));
    assign pf_issue   = (state_q == IDLE) && !req_valid && active_q && !mem_valid_q
                        && (vcnt_q < FULL);
    assign wr_idx     = rd_ptr_q + vcnt_q[PW-1:0];
    assign pf_addr    = head_addr_q + (ADDR_WIDTH'(vcnt_q) << 2);

    always_comb begin
        vcnt_d = vcnt_q;
        if (miss)
            vcnt_d = '0;
        else
            vcnt_d = vcnt_q + (PW+1)'(append) - (PW+1)'(hit_fifo);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            req_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            head_addr_q <= '0;
            rd_ptr_q    <= '0;
            vcnt_q      <= '0;
            active_q    <= 1'b0;
        end else begin
            // NOTE: every register here takes <= so all branches see pre-edge values.
            vcnt_q      <= vcnt_d;
            req_ready_q <= 1'b0;
            if (mem_valid_q && mem_ready)
                mem_valid_q <= 1'b0;
            if (pf_issue) begin
                mem_valid_q <= 1'b1;
                mem_addr_q  <= pf_addr;
            end
            case (state_q)
                IDLE: begin
                    if (hit_fifo) begin
                        req_ready_q <= 1'b1;
                        req_rdata_q <= buf_q[rd_ptr_q];
                        rd_ptr_q    <= rd_ptr_q + 1'b1;
                        head_addr_q <= head_addr_q + WORD_BYTES;
                        state_q     <= HIT_RSP;
                    end else if (wait_hit && mem_ready) begin
                        req_ready_q <= 1'b1;
                        req_rdata_q <= mem_rdata;
                        rd_ptr_q    <= rd_ptr_q + 1'b1;
                        head_addr_q <= head_addr_q + WORD_BYTES;
                        state_q     <= HIT_RSP;
                    end else if (wait_hit) begin
                        state_q <= WAIT_PF;
                    end else if (miss) begin
                        state_q <= (pf_busy && !mem_ready) ? DRAIN : DEMAND;
                    end
                end
                HIT_RSP: state_q <= IDLE;
                WAIT_PF: begin
                    if (mem_ready) begin
                        req_ready_q <= 1'b1;
                        req_rdata_q <= mem_rdata;
                        rd_ptr_q    <= rd_ptr_q + 1'b1;
                        head_addr_q <= head_addr_q + WORD_BYTES;
                        state_q     <= HIT_RSP;
                    end
                end
                DRAIN: begin
                    if (mem_ready)
                        state_q <= DEMAND;
                end
                DEMAND: begin
                    // Requester holds req_addr until req_ready, so it is read live here.
                    if (!mem_valid_q) begin
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= req_addr & WORD_MASK;
                    end else if (mem_ready) begin
                        req_ready_q <= 1'b1;
                        req_rdata_q <= mem_rdata;
                        head_addr_q <= mem_addr_q + WORD_BYTES;
                        active_q    <= 1'b1;
                        state_q     <= DEMAND_RSP;
                    end
                end
                DEMAND_RSP: state_q <= IDLE;
                default:    state_q <= IDLE;
            endcase
        end
    end

    // NOTE: data storage has no reset; vcnt alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (append)
            buf_q[wr_idx] <= mem_rdata;
    end

    assign req_ready = req_ready_q;
    assign req_rdata = req_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;

`ifdef PREFETCH_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, issue_cnt_q;
    logic        hit_evt, miss_evt;

    assign hit_evt  = hit_fifo || (wait_hit && mem_ready) || ((state_q == WAIT_PF) && mem_ready);
    assign miss_evt = (state_q == DEMAND) && mem_valid_q && mem_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (hit_evt && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + 1'b1;
            if (miss_evt && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 1'b1;
            if (pf_issue && (issue_cnt_q != '1))
                issue_cnt_q <= issue_cnt_q + 1'b1;
        end
    end

    assign dbg_hit_count      = hit_cnt_q;
    assign dbg_miss_count     = miss_cnt_q;
    assign dbg_pf_issue_count = issue_cnt_q;
`endif

endmodule

// File: tb/tb_icache_stream_prefetch.sv
// Directed bench for icache_stream_prefetch; imem word i returns 32'h1000_0000 + i.
module tb_icache_stream_prefetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
`ifdef PREFETCH_STATS_EN
    logic [31:0] dbg_hit_count, dbg_miss_count, dbg_pf_issue_count;
`endif

    icache_stream_prefetch #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
`ifdef PREFETCH_STATS_EN
        ,
        .dbg_hit_count      (dbg_hit_count),
        .dbg_miss_count     (dbg_miss_count),
        .dbg_pf_issue_count (dbg_pf_issue_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          resp_cnt = 0;
    int          rdy_cyc  = 0;
    logic [31:0] mem_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    // imem model: answers after mem_lat cycles of mem_valid with a one-cycle mem_ready pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                resp_cnt  = 0;
            end else if (mem_valid && resetn) begin
                resp_cnt++;
                if (resp_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = 32'h1000_0000 + {2'b00, mem_addr[31:2]};
                    mem_log.push_back(mem_addr);
                    rdy_cyc   = cyc;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] a, output int lat, output logic [31:0] d,
                          output int rcyc);
        bit got;
        got  = 1'b0;
        lat  = 0;
        d    = '0;
        rcyc = 0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 1; i <= 200 && !got; i++) begin
            step();
            if (req_ready === 1'b1) begin
                got  = 1'b1;
                lat  = i;
                d    = req_rdata;
                rcyc = cyc;
            end
        end
        req_valid = 1'b0;
        check("req_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_mem_valid(output logic [31:0] a);
        bit got;
        got = 1'b0;
        a   = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (mem_valid === 1'b1) begin
                got = 1'b1;
                a   = mem_addr;
            end else begin
                step();
            end
        end
        check("mem_valid_timeout", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int          lat, rcyc, n;
        logic [31:0] d, a;

        // Reset state
        step(); step(); step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_req_rdata", req_rdata, 32'd0);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        resetn = 1'b1;
        step(); step();
        check("no_pf_before_miss", {31'd0, mem_valid}, 32'd0);

        // 1: demand miss at 0x00, then four prefetches and the stream stops
        do_req(32'h0, lat, d, rcyc);
        check("s1_rdata", d, 32'h1000_0000);
        check("s1_demand_addr", mem_log[0], 32'h0);
        repeat (30) step();
        check("s1_log_size", 32'(mem_log.size()), 32'd5);
        check("s1_pf0", mem_log[1], 32'h04);
        check("s1_pf1", mem_log[2], 32'h08);
        check("s1_pf2", mem_log[3], 32'h0C);
        check("s1_pf3", mem_log[4], 32'h10);
        check("s1_full_idle", {31'd0, mem_valid}, 32'd0);

        // 2: hit on the head entry
        do_req(32'h04, lat, d, rcyc);
        check("s2_latency", 32'(lat), 32'd1);
        check("s2_rdata", d, 32'h1000_0001);
        check("s2_no_demand", 32'(mem_log.size()), 32'd5);
        mem_lat = 8;
        wait_mem_valid(a);
        check("s2_next_pf", a, 32'h14);
`ifdef PREFETCH_STATS_EN
        check("stats_hit", dbg_hit_count, 32'd1);
        check("stats_miss", dbg_miss_count, 32'd1);
        check("stats_issue", dbg_pf_issue_count, 32'd5);
`endif

        // 3: miss while prefetch 0x14 is in flight
        do_req(32'h40, lat, d, rcyc);
        check("s3_rdata", d, 32'h1000_0010);
        check("s3_log_size", 32'(mem_log.size()), 32'd7);
        check("s3_drained", mem_log[5], 32'h14);
        check("s3_demand", mem_log[6], 32'h40);
        wait_mem_valid(a);
        check("s3_restart", a, 32'h44);

        // 4: request equal to the in-flight prefetch
        n = mem_log.size();
        do_req(32'h44, lat, d, rcyc);
        check("s4_rdata", d, 32'h1000_0011);
        check("s4_ready_after_mem", 32'(rcyc - rdy_cyc), 32'd1);
        check("s4_single_access", 32'(mem_log.size()), 32'(n + 1));
        check("s4_access_addr", mem_log[n], 32'h44);
        wait_mem_valid(a);
        check("s4_next_pf", a, 32'h48);

        // 5: top-of-memory wrap
        mem_lat = 1;
        do_req(32'hFFFF_FFFC, lat, d, rcyc);
        check("s5_rdata", d, 32'h4FFF_FFFF);
        wait_mem_valid(a);
        check("s5_wrap_pf", a, 32'h0);

        // 6: reset during an imem transaction
        mem_lat = 8;
        step();
        wait_mem_valid(a);
        resetn = 1'b0;
        #1;
        check("s6_mem_valid_rst", {31'd0, mem_valid}, 32'd0);
        check("s6_req_ready_rst", {31'd0, req_ready}, 32'd0);
        step(); step();
        resetn  = 1'b1;
        mem_lat = 1;
        step(); step();
        check("s6_no_pf_after_rst", {31'd0, mem_valid}, 32'd0);
        do_req(32'h04, lat, d, rcyc);
        check("s6_is_miss", {31'd0, lat >= 3}, 32'd1);
        check("s6_rdata", d, 32'h1000_0001);
        check("s6_demand_addr", mem_log[mem_log.size() - 1], 32'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
